disassemble_pack: RTL

//   Receive side of the 176-bit game-state packet (sync 16'h55AA, player_x, player_y,
//   3x {wave_y, 40-bit wave_bitfield}). Takes a byte stream from the link deserialiser,

---
 rtl/disassemble_pack.sv | 139 +++++++++++++
 1 files changed

// File: rtl/disassemble_pack.sv
// Receive side of the 176-bit game-state packet: hunts for the 0xAA,0x55 sync word,
// collects 20 payload bytes and presents the decoded fields with a one-cycle pkt_valid.
module disassemble_pack #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  player_x,
    output logic [7:0]  player_y,
    output logic [7:0]  wave_y0,
    output logic [39:0] wave_bitfield0,
    output logic [7:0]  wave_y1,
    output logic [39:0] wave_bitfield1,
    output logic [7:0]  wave_y2,
    output logic [39:0] wave_bitfield2,
    output logic        pkt_valid,
    output logic        frame_err,
    output logic [15:0] pkt_count
);

    localparam int unsigned    CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  IDLE_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit             TMO_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        HUNT0   = 2'd0,
        HUNT1   = 2'd1,
        PAYLOAD = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t          r_state;
    logic [4:0]      r_idx;
    logic [CW-1:0]   r_idle;
    logic [159:0]    r_pay;
    logic [159:0]    r_fields;
    logic            r_pkt_valid;
    logic            r_frame_err;
    logic [15:0]     r_pkt_count;

    logic            w_timeout;
    logic [CW-1:0]   w_idle_next;
    logic [7:0]      w_bit_base;
    logic            w_is_aa;

    // The byte arriving on the expiry cycle wins, so expiry needs an idle cycle.
    assign w_timeout   = TMO_EN && !rx_valid && (r_idle == IDLE_LAST);
    assign w_idle_next = TMO_EN ? (r_idle + CW'(1)) : '0;
    assign w_bit_base  = {r_idx, 3'b000};
    assign w_is_aa     = rx_valid && (rx_data == 8'hAA);

    // Receive FSM: sync hunt, payload collection, delivery and inter-byte timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HUNT0;
            r_idx       <= 5'd0;
            r_idle      <= '0;
            r_pay       <= 160'd0;
            r_fields    <= 160'd0;
            r_pkt_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_pkt_count <= 16'd0;
        end else begin
            r_pkt_valid <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                HUNT0: begin
                    r_idle <= '0;
                    if (w_is_aa) begin
                        r_state <= HUNT1;
                    end
                end
                HUNT1: begin
                    if (rx_valid) begin
                        r_idle <= '0;
                        if (rx_data == 8'h55) begin
                            r_state <= PAYLOAD;
                            r_idx   <= 5'd0;
                        end else if (rx_data != 8'hAA) begin
                            r_state <= HUNT0;
                        end
                    end else if (w_timeout) begin
                        r_state     <= HUNT0;
                        r_frame_err <= 1'b1;
                        r_idle      <= '0;
                    end else begin
                        r_idle <= w_idle_next;
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        r_idle                  <= '0;
                        r_pay[w_bit_base +: 8]  <= rx_data;
                        if (r_idx == 5'd19) begin
                            r_state <= DELIVER;
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end else if (w_timeout) begin
                        r_state     <= HUNT0;
                        r_frame_err <= 1'b1;
                        r_idle      <= '0;
                    end else begin
                        r_idle <= w_idle_next;
                    end
                end
                DELIVER: begin
                    // A byte arriving here is treated as the first sync candidate.
                    r_fields    <= r_pay;
                    r_pkt_valid <= 1'b1;
                    r_pkt_count <= r_pkt_count + 16'd1;
                    r_idx       <= 5'd0;
                    r_idle      <= '0;
                    r_state     <= w_is_aa ? HUNT1 : HUNT0;
                end
                default: begin
                    r_state <= HUNT0;
                    r_idx   <= 5'd0;
                    r_idle  <= '0;
                end
            endcase
        end
    end

    assign player_x       = r_fields[7:0];
    assign player_y       = r_fields[15:8];
    assign wave_y0        = r_fields[23:16];
    assign wave_bitfield0 = r_fields[63:24];
    assign wave_y1        = r_fields[71:64];
    assign wave_bitfield1 = r_fields[111:72];
    assign wave_y2        = r_fields[119:112];
    assign wave_bitfield2 = r_fields[159:120];
    assign pkt_valid      = r_pkt_valid;
    assign frame_err      = r_frame_err;
    assign pkt_count      = r_pkt_count;

endmodule
